slave_bank: RTL



---
 rtl/slave_bank.sv | 96 +++++++++
 1 files changed

// File: rtl/slave_bank.sv
// Single-port write slave: accepts one request, commits it after a one-cycle WRITE phase,
// then holds ready low for BUSY_CYCLES cycles. Keeps per-entry valid bits and a write count.
module slave_bank #(
  parameter int unsigned BUSY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [2:0] addr_in,
  input  logic [2:0] value_in,
  input  logic       clr,
  input  logic [2:0] rd_addr,
  output logic       ready,
  output logic [2:0] rd_data,
  output logic [7:0] entry_valid,
  output logic [7:0] wr_count
);

  typedef enum logic [1:0] {StIdle, StWrite, StBusy} state_e;

  state_e     state_q;
  logic [2:0] busy_cnt_q;
  logic [2:0] wr_addr_q;
  logic [2:0] wr_val_q;
  logic [2:0] mem_q [8];

  logic       commit;
  logic [7:0] commit_mask;

  assign commit      = (state_q == StWrite);
  assign commit_mask = 8'd1 << wr_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_cnt_q  <= '0;
      wr_addr_q   <= '0;
      wr_val_q    <= '0;
      ready       <= 1'b0;
      rd_data     <= '0;
      entry_valid <= '0;
      wr_count    <= '0;
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      // ready mirrors whether the state being entered is StIdle
      unique case (state_q)
        StIdle: begin
          if (ready && valid) begin
            state_q   <= StWrite;
            wr_addr_q <= addr_in;
            wr_val_q  <= value_in;
            ready     <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        StWrite: begin
          mem_q[wr_addr_q] <= wr_val_q;
          if (BUSY_CYCLES == 0) begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end else begin
            state_q    <= StBusy;
            busy_cnt_q <= 3'(BUSY_CYCLES);
            ready      <= 1'b0;
          end
        end
        StBusy: begin
          busy_cnt_q <= busy_cnt_q - 3'd1;
          if (busy_cnt_q <= 3'd1) begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end else begin
            ready <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b0;
        end
      endcase

      // write-first bypass when the commit targets the address being read
      rd_data <= (commit && (wr_addr_q == rd_addr)) ? wr_val_q : mem_q[rd_addr];

      if (clr) begin
        entry_valid <= commit ? commit_mask : 8'h00;
        wr_count    <= commit ? 8'd1 : 8'd0;
      end else if (commit) begin
        entry_valid <= entry_valid | commit_mask;
        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule
